// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Raster timing generator for 640x480@60 Hz VGA driven by the 25 MHz pixel
// clock. It supplies the pixel coordinate and visible-area flag to the sprite
// ROM readers and the renderer, and sync pulses to the VGA/HDMI encoder. A
// short delay line on hs/vs/blank lets the encoder see sync and blank lined
// up with RGB that has gone through registered pipeline stages.
//
// Ports
//   vga_clk     in   1   pixel clock, all state on the rising edge
//   reset       in   1   asynchronous, active-high reset
//   DrawX       out  10  horizontal count, 0..H_TOTAL-1
//   DrawY       out  10  vertical count, 0..V_TOTAL-1
//   blank       out  1   1 = visible pixel, 0 = blanking interval
//   hs          out  1   horizontal sync, active low
//   vs          out  1   vertical sync, active low
//   frame_start out  1   high while (DrawX,DrawY) == (0,0)
//   line_start  out  1   high while DrawX == 0
//   frame_count out  8   frames started since reset, wraps 255 -> 0
//   hs_d        out  1   hs delayed PIPE_DELAY cycles
//   vs_d        out  1   vs delayed PIPE_DELAY cycles
//   blank_d     out  1   blank delayed PIPE_DELAY cycles
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int PIPE_DELAY = 2
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic       line_start,
    output logic [7:0] frame_count,
    output logic       hs_d,
    output logic       vs_d,
    output logic       blank_d
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Sync windows kept as 32-bit integers so an end boundary equal to 1024
    // does not alias to zero in a 10-bit compare.
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_STOP  = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_STOP  = V_VISIBLE + V_FRONT + V_SYNC;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Elaboration-time guard on the geometry: counters are 10 bits wide.
    if ((H_TOTAL > 1024) || (V_TOTAL > 1024) || (H_TOTAL < 2) || (V_TOTAL < 2)
        || (PIPE_DELAY < 0)) begin : g_bad_params
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must lie in 2..1024 and PIPE_DELAY >= 0");
    end

    // Counter state and registered decodes
    logic [9:0] h_cnt_r;
    logic [9:0] v_cnt_r;
    logic       blank_r;
    logic       hs_r;
    logic       vs_r;
    logic       frame_start_r;
    logic       line_start_r;
    logic [7:0] frame_count_r;

    // Next-count values and the decodes computed from them
    logic       h_wrap_s;
    logic [9:0] h_next_s;
    logic [9:0] v_next_s;
    logic       blank_next_s;
    logic       hs_next_s;
    logic       vs_next_s;
    logic       frame_start_next_s;
    logic       line_start_next_s;

    // Next raster position: DrawX wraps each line, DrawY advances on that wrap.
    always_comb begin
        h_wrap_s = (h_cnt_r == H_LAST);
        if (h_wrap_s) begin
            h_next_s = 10'd0;
            if (v_cnt_r == V_LAST) begin
                v_next_s = 10'd0;
            end else begin
                v_next_s = v_cnt_r + 10'd1;
            end
        end else begin
            h_next_s = h_cnt_r + 10'd1;
            v_next_s = v_cnt_r;
        end
    end

    // Decode flags from the next position so that, once registered, they
    // describe exactly the coordinate presented on DrawX/DrawY.
    always_comb begin
        blank_next_s       = (int'(h_next_s) < H_VISIBLE) && (int'(v_next_s) < V_VISIBLE);
        hs_next_s          = !((int'(h_next_s) >= HS_START) && (int'(h_next_s) < HS_STOP));
        vs_next_s          = !((int'(v_next_s) >= VS_START) && (int'(v_next_s) < VS_STOP));
        line_start_next_s  = (h_next_s == 10'd0);
        frame_start_next_s = (h_next_s == 10'd0) && (v_next_s == 10'd0);
    end

    // Raster counters, registered decodes and the frame counter. Reset parks
    // the counters on the last pixel so the first edge lands on (0,0).
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            h_cnt_r       <= H_LAST;
            v_cnt_r       <= V_LAST;
            blank_r       <= 1'b0;
            hs_r          <= 1'b1;
            vs_r          <= 1'b1;
            frame_start_r <= 1'b0;
            line_start_r  <= 1'b0;
            frame_count_r <= 8'd0;
        end else begin
            h_cnt_r       <= h_next_s;
            v_cnt_r       <= v_next_s;
            blank_r       <= blank_next_s;
            hs_r          <= hs_next_s;
            vs_r          <= vs_next_s;
            frame_start_r <= frame_start_next_s;
            line_start_r  <= line_start_next_s;
            if (frame_start_next_s) begin
                frame_count_r <= frame_count_r + 8'd1;
            end else begin
                frame_count_r <= frame_count_r;
            end
        end
    end

    assign DrawX       = h_cnt_r;
    assign DrawY       = v_cnt_r;
    assign blank       = blank_r;
    assign hs          = hs_r;
    assign vs          = vs_r;
    assign frame_start = frame_start_r;
    assign line_start  = line_start_r;
    assign frame_count = frame_count_r;

    if (PIPE_DELAY == 0) begin : g_no_pipe
        assign hs_d    = hs_r;
        assign vs_d    = vs_r;
        assign blank_d = blank_r;
    end else begin : g_pipe
        logic [PIPE_DELAY-1:0] hs_pipe_r;
        logic [PIPE_DELAY-1:0] vs_pipe_r;
        logic [PIPE_DELAY-1:0] blank_pipe_r;

        // Shift registers; stage 0 takes the live flag, the last stage drives
        // the output. Stages start at the inactive levels.
        always_ff @(posedge vga_clk or posedge reset) begin
            if (reset) begin
                hs_pipe_r    <= {PIPE_DELAY{1'b1}};
                vs_pipe_r    <= {PIPE_DELAY{1'b1}};
                blank_pipe_r <= {PIPE_DELAY{1'b0}};
            end else begin
                hs_pipe_r[0]    <= hs_r;
                vs_pipe_r[0]    <= vs_r;
                blank_pipe_r[0] <= blank_r;
                for (int i = 1; i < PIPE_DELAY; i++) begin
                    hs_pipe_r[i]    <= hs_pipe_r[i-1];
                    vs_pipe_r[i]    <= vs_pipe_r[i-1];
                    blank_pipe_r[i] <= blank_pipe_r[i-1];
                end
            end
        end

        assign hs_d    = hs_pipe_r[PIPE_DELAY-1];
        assign vs_d    = vs_pipe_r[PIPE_DELAY-1];
        assign blank_d = blank_pipe_r[PIPE_DELAY-1];
    end

endmodule
